// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader state encoding and default memory geometry
package prog_loader_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;
   typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, CLEAR, RUN} state_t;
   function automatic state_t first_state(input logic i_nz, input logic d_nz);
      return i_nz ? LOAD_I : d_nz ? LOAD_D : CLEAR;
   endfunction
endpackage

// File: rtl/load_addr_cnt.sv
// load_addr_cnt: per-memory write address and accepted-word counter
module load_addr_cnt import prog_loader_pkg::*; #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] BASE = '0
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              init,
   input  logic              inc,
   input  logic [ADDR_W-1:0] count,
   output logic [ADDR_W-1:0] addr,
   output logic              last,
   output logic              empty
);
   logic [ADDR_W-1:0] k, n;
   assign last = k == n - ADDR_W'(1);
   assign empty = n == '0;
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         addr <= '0;
         k <= '0;
         n <= '0;
      end else if (init) begin
         addr <= BASE;
         k <= '0;
         n <= count;
      end else if (inc) begin
         addr <= addr + ADDR_W'(1);
         k <= k + ADDR_W'(1);
      end
   end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program and data image into CPU memories, clears the datapath, then releases the CPU
module prog_loader import prog_loader_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CLR_CYCLES = 2,
   parameter logic [ADDR_W-1:0] INSTR_BASE = '0,
   parameter logic [ADDR_W-1:0] DATA_BASE = '0
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] instr_count,
   input  logic [ADDR_W-1:0] data_count,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              test_normal,
   output logic              ext_instr_we,
   output logic [ADDR_W-1:0] ext_instr_addr,
   output logic [DATA_W-1:0] ext_instr_data,
   output logic              ext_data_write_en,
   output logic [ADDR_W-1:0] ext_data_addr,
   output logic [DATA_W-1:0] ext_data_data,
   output logic              cpu_clr,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2(CLR_CYCLES + 1);
   state_t state, nxt;
   logic [CW-1:0] clr_cnt;
   logic acc, go, inc_i, inc_d, i_last, d_last, i_empty, d_empty;
   logic [ADDR_W-1:0] i_addr, d_addr;
   assign s_ready = state == LOAD_I || state == LOAD_D;
   assign acc = s_valid && s_ready;
   assign go = (state == IDLE || state == RUN) && start && !abort;
   assign inc_i = acc && state == LOAD_I && !abort;
   assign inc_d = acc && state == LOAD_D && !abort;
   load_addr_cnt #(.ADDR_W(ADDR_W), .BASE(INSTR_BASE)) u_instr (
      .clk(clk), .clr_n(clr_n), .init(go), .inc(inc_i), .count(instr_count),
      .addr(i_addr), .last(i_last), .empty(i_empty)
   );
   load_addr_cnt #(.ADDR_W(ADDR_W), .BASE(DATA_BASE)) u_data (
      .clk(clk), .clr_n(clr_n), .init(go), .inc(inc_d), .count(data_count),
      .addr(d_addr), .last(d_last), .empty(d_empty)
   );
   // an empty phase is never entered, the empty terms only guard against getting stuck
   always_comb begin
      nxt = state;
      case (state)
         IDLE, RUN: nxt = start ? first_state(instr_count != '0, data_count != '0) : state;
         LOAD_I:    nxt = (acc && i_last) || i_empty ? (d_empty ? CLEAR : LOAD_D) : LOAD_I;
         LOAD_D:    nxt = (acc && d_last) || d_empty ? CLEAR : LOAD_D;
         CLEAR:     nxt = clr_cnt == CW'(CLR_CYCLES - 1) ? RUN : CLEAR;
         default:   nxt = IDLE;
      endcase
      if (abort) nxt = IDLE;
   end
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state <= IDLE;
         clr_cnt <= '0;
         ext_instr_we <= 1'b0;
         ext_instr_addr <= '0;
         ext_instr_data <= '0;
         ext_data_write_en <= 1'b0;
         ext_data_addr <= '0;
         ext_data_data <= '0;
         cpu_clr <= 1'b0;
         test_normal <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= nxt;
         clr_cnt <= state == CLEAR ? clr_cnt + CW'(1) : '0;
         ext_instr_we <= inc_i;
         ext_data_write_en <= inc_d;
         if (inc_i) begin
            ext_instr_addr <= i_addr;
            ext_instr_data <= s_data;
         end
         if (inc_d) begin
            ext_data_addr <= d_addr;
            ext_data_data <= s_data;
         end
         cpu_clr <= nxt == CLEAR;
         test_normal <= nxt inside {IDLE, LOAD_I, LOAD_D};
         busy <= nxt inside {LOAD_I, LOAD_D, CLEAR};
         done <= nxt == RUN;
      end
   end
endmodule
